pipe_addsub: RTL and testbench

PIPE_ADDSUB -- requirements
Module: pipe_addsub

---
 rtl/pipe_addsub.sv | 158 +++++++++++++++
 tb/tb_pipe_addsub.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// Pipelined signed adder/subtractor: 4-bit CLA groups with rippled group carries,
// carry chain split over STAGES registered slices. Define PIPE_ADDSUB_SAT_EN to enable saturation.
module pipe_addsub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Error,
    output logic             Zero
);
    localparam int unsigned SLICE  = WIDTH / STAGES;
    localparam int unsigned GROUPS = SLICE / 4;
    localparam int unsigned LAST   = STAGES - 1;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // One slice of the adder: carry-lookahead inside each 4-bit group, ripple between groups.
    function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b,
                                                 input logic             cin);
        logic [SLICE:0] r;
        logic [3:0]     g;
        logic [3:0]     p;
        logic [4:0]     cc;
        logic           c;
        r = '0;
        c = cin;
        for (int unsigned k = 0; k < GROUPS; k++) begin
            g     = a[4*k +: 4] & b[4*k +: 4];
            p     = a[4*k +: 4] ^ b[4*k +: 4];
            cc[0] = c;
            cc[1] = g[0] | (p[0] & cc[0]);
            cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cc[0]);
            cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cc[0]);
            cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & cc[0]);
            r[4*k +: 4] = p ^ cc[3:0];
            c = cc[4];
        end
        r[SLICE] = c;
        return r;
    endfunction

    // Stage registers: entry s holds the beat after slice s has been summed.
    logic             v_q   [STAGES];
    logic             sub_q [STAGES];
    logic             sat_q [STAGES];
    logic             c_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             err_q;
    logic             zero_q;

    // Stage inputs and combinational results.
    logic             v_i   [STAGES];
    logic             sub_i [STAGES];
    logic             sat_i [STAGES];
    logic             c_i   [STAGES];
    logic [WIDTH-1:0] a_i   [STAGES];
    logic [WIDTH-1:0] b_i   [STAGES];
    logic [WIDTH-1:0] s_i   [STAGES];
    logic             nxt_c [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];

    logic             stall;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] fin_sum;
    logic             a_msb;
    logic             b_msb;
    logic             ovf;
    logic             unused;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [SLICE:0] res;
        if (s == 0) begin : g_head
            assign v_i[s]   = in_valid;
            assign sub_i[s] = sub;
            assign sat_i[s] = sat;
            assign c_i[s]   = sub;
            assign a_i[s]   = A;
            assign b_i[s]   = B ^ {WIDTH{sub}};
            assign s_i[s]   = '0;
        end else begin : g_body
            assign v_i[s]   = v_q[s-1];
            assign sub_i[s] = sub_q[s-1];
            assign sat_i[s] = sat_q[s-1];
            assign c_i[s]   = c_q[s-1];
            assign a_i[s]   = a_q[s-1];
            assign b_i[s]   = b_q[s-1];
            assign s_i[s]   = s_q[s-1];
        end
        assign res      = slice_add(a_i[s][s*SLICE +: SLICE], b_i[s][s*SLICE +: SLICE], c_i[s]);
        assign nxt_c[s] = res[SLICE];
        assign nxt_s[s] = s_i[s] | (WIDTH'(res[SLICE-1:0]) << (s * SLICE));
    end

    // Overflow judged on the wrapped result; bubbles never report an error.
    assign raw   = nxt_s[LAST];
    assign a_msb = a_i[LAST][WIDTH-1];
    assign b_msb = b_i[LAST][WIDTH-1];
    assign ovf   = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);

`ifdef PIPE_ADDSUB_SAT_EN
    assign fin_sum = (sat_i[LAST] && ovf) ? (a_msb ? SAT_MIN : SAT_MAX) : raw;
`else
    assign fin_sum = raw;
`endif

    assign stall     = v_q[LAST] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v_q[LAST];
    assign Sum       = s_q[LAST];
    assign Error     = err_q;
    assign Zero      = zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
                sat_q[k] <= 1'b0;
                c_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
            end
            err_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!stall) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k]   <= v_i[k];
                sub_q[k] <= sub_i[k];
                sat_q[k] <= sat_i[k];
                c_q[k]   <= nxt_c[k];
                a_q[k]   <= a_i[k];
                b_q[k]   <= b_i[k];
                s_q[k]   <= (k == LAST) ? fin_sum : nxt_s[k];
            end
            err_q  <= ovf & v_i[LAST];
            zero_q <= (fin_sum == '0);
        end
    end

    // Last-stage operand/carry copies are never consumed; synthesis trims them.
    assign unused = ^{a_q[LAST], b_q[LAST], c_q[LAST], sub_q[LAST], sat_q[LAST], sat_i[LAST]};

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (WIDTH=16, STAGES=2): directed cases plus a
// randomized stream scored against an integer-arithmetic reference model.
module tb_pipe_addsub;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 2;
`ifdef PIPE_ADDSUB_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] sum;
        logic        err;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        sub;
    logic        sat;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum_o;
    logic        err_o;
    logic        zero_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   n_acc    = 0;
    exp_t exp_q[$];

    pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(op_a), .B(op_b), .sub(sub), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(sum_o), .Error(err_o), .Zero(zero_o)
    );

    always #5 clk = ~clk;

    // Reference: exact integer add/subtract, then range check, wrap or clamp.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic s, input logic st);
        int   ia;
        int   ib;
        int   r;
        exp_t e;
        ia    = int'($signed(a));
        ib    = int'($signed(b));
        r     = s ? (ia - ib) : (ia + ib);
        e.err = (r > 32767) || (r < -32768);
        e.sum = 16'(r);
        if (SAT_ON && st && e.err) e.sum = (r > 0) ? 16'h7FFF : 16'h8000;
        e.zero = (e.sum == 16'h0000);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic s, input logic st);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        sub      = s;
        sat      = st;
    endtask

    // One clock: score the output handshake, record an accepted beat, advance.
    task automatic tick();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            chk("unexpected_beat", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("beat_sum", 32'(sum_o), 32'(e.sum));
                chk("beat_error", 32'(err_o), 32'(e.err));
                chk("beat_zero", 32'(zero_o), 32'(e.zero));
                n_out++;
            end
        end
        if (rst) exp_q.delete();
        else if (in_valid && in_ready) begin
            exp_q.push_back(model(op_a, op_b, sub, sat));
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    exp_t first;
    int   base;

    initial begin
        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum_o), 32'd0);
        chk("reset_error", 32'(err_o), 32'd0);
        chk("reset_zero", 32'(zero_o), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Positive overflow wraps, latency of two cycles
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("ovf_not_early", 32'(out_valid), 32'd0);
        tick();
        chk("ovf_valid", 32'(out_valid), 32'd1);
        chk("ovf_sum", 32'(sum_o), 32'h8000);
        chk("ovf_error", 32'(err_o), 32'd1);
        chk("ovf_zero", 32'(zero_o), 32'd0);
        tick();

        // Negative overflow with saturation requested
        drive(16'h8000, 16'h0001, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("sat_valid", 32'(out_valid), 32'd1);
        chk("sat_sum", 32'(sum_o), SAT_ON ? 32'h8000 : 32'h7FFF);
        chk("sat_error", 32'(err_o), 32'd1);
        tick();

        // Equal operands subtract to zero
        drive(16'h1234, 16'h1234, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("zero_valid", 32'(out_valid), 32'd1);
        chk("zero_sum", 32'(sum_o), 32'h0000);
        chk("zero_flag", 32'(zero_o), 32'd1);
        chk("zero_error", 32'(err_o), 32'd0);
        tick();

        // Backpressure: three beats, downstream stalled four cycles, then drain
        out_ready = 1'b0;
        drive(16'h0100, 16'h0023, 1'b0, 1'b0);
        first = model(16'h0100, 16'h0023, 1'b0, 1'b0);
        tick();
        drive(16'h7000, 16'h7000, 1'b0, 1'b0);
        tick();
        drive(16'h0005, 16'h0009, 1'b1, 1'b0);
        base = n_out;
        for (int i = 0; i < 4; i++) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_hold_sum", 32'(sum_o), 32'(first.sum));
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) in_valid = 1'b0;
            chk("drain_rate", 32'(n_out - base), 32'(i + 1));
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(out_valid), 32'd0);

        // Reset with two beats in flight
        drive(16'h0A0A, 16'h0101, 1'b0, 1'b0);
        tick();
        drive(16'h0202, 16'h0303, 1'b1, 1'b0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum_o), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst_no_stale", 32'(out_valid), 32'd0);
        end

        // Random stream with random backpressure
        base = n_acc;
        for (int cyc = 0; cyc < 20000 && (n_acc - base) < 1024; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            op_a      = 16'($urandom);
            op_b      = 16'($urandom);
            sub       = 1'($urandom);
            sat       = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("random_accepted", 32'(n_acc - base), 32'd1024);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("random_drained", 32'(exp_q.size()), 32'd0);
        tick();
        chk("random_idle", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
